// File: rtl/vga_console_if.sv
// -----------------------------------------------------------------------------
// vga_console_if
// Bundles the CPU command handshake and the text-mode VRAM ports of the
// console engine.
//   cmd_valid / cmd_ready : command handshake, accept on valid & ready
//   cmd_op                : 0=PUTC, 1=CLEAR, 2=SETCOLOR, 3=SETPOS
//   cmd_data              : command operand
//   vram_we/waddr/wdata   : VRAM word write port (registered in the engine)
//   vram_raddr/rdata      : VRAM read port, rdata valid one cycle after raddr
// master = CPU/VRAM side, slave = console engine.
// -----------------------------------------------------------------------------
interface vga_console_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic        vram_we;
    logic [31:0] vram_waddr;
    logic [31:0] vram_wdata;
    logic [31:0] vram_raddr;
    logic [31:0] vram_rdata;

    modport master (
        output cmd_valid, cmd_op, cmd_data, vram_rdata,
        input  cmd_ready, vram_we, vram_waddr, vram_wdata, vram_raddr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, vram_rdata,
        output cmd_ready, vram_we, vram_waddr, vram_wdata, vram_raddr
    );
endinterface

// File: rtl/vga_console.sv
// -----------------------------------------------------------------------------
// vga_console
// Command-driven text console engine. Turns PUTC / CLEAR / SETCOLOR / SETPOS
// commands into VRAM cell writes, tracks the cursor, wraps lines and scrolls
// the screen by copying VRAM up one row through the read port.
// Cell format: {4'b0, colour[11:0], 9'b0, ascii[6:0]}, address = row*COLS+col.
// Ports:
//   clk      : system clock, rising edge
//   clr      : synchronous active-high reset
//   bus      : command handshake and VRAM ports (slave modport)
//   cur_col  : current cursor column
//   cur_row  : current cursor row
//   busy     : engine not idle
// -----------------------------------------------------------------------------
module vga_console #(
    parameter int          COLS          = 80,
    parameter int          ROWS          = 50,
    parameter logic [11:0] DEFAULT_COLOR = 12'hFFF
) (
    input  logic              clk,
    input  logic              clr,
    vga_console_if.slave      bus,
    output logic [6:0]        cur_col,
    output logic [5:0]        cur_row,
    output logic              busy
);

    typedef logic [15:0] addr_t;

    localparam addr_t COPY_LAST  = addr_t'(COLS * (ROWS - 1) - 1);
    localparam addr_t CELL_LAST  = addr_t'(COLS * ROWS - 1);
    localparam addr_t SCROLL_SRC = addr_t'(COLS);
    localparam logic [6:0] COL_MAX = 7'(COLS - 1);
    localparam logic [5:0] ROW_MAX = 6'(ROWS - 1);

    localparam logic [1:0] OP_PUTC     = 2'd0;
    localparam logic [1:0] OP_CLEAR    = 2'd1;
    localparam logic [1:0] OP_SETCOLOR = 2'd2;
    localparam logic [1:0] OP_SETPOS   = 2'd3;

    localparam logic [6:0] CH_LF    = 7'h0A;
    localparam logic [6:0] CH_CR    = 7'h0D;
    localparam logic [6:0] CH_BS    = 7'h08;
    localparam logic [6:0] CH_SPACE = 7'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUTC,     // issue the character write
        S_ADV,      // move the cursor, possibly start a scroll
        S_COPY_RD,  // scroll: read address presented
        S_COPY_WR,  // scroll: read data valid, write it one row up
        S_BLANK,    // scroll: blank the last row
        S_CLEAR     // blank the whole screen
    } state_t;

    function automatic logic [31:0] cell_word(input logic [11:0] color, input logic [6:0] ch);
        return {4'b0000, color, 9'b0_0000_0000, ch};
    endfunction

    state_t      state_r, state_s;
    logic [6:0]  col_r, col_s;
    logic [5:0]  row_r, row_s;
    logic [11:0] color_r, color_s;
    logic [6:0]  ch_r, ch_s;
    addr_t       addr_r, addr_s;
    logic        vram_we_r, vram_we_s;
    addr_t       waddr_r, waddr_s;
    logic [31:0] wdata_r, wdata_s;
    addr_t       raddr_r, raddr_s;

    logic        cmd_ready_s;
    logic        cmd_fire_s;
    logic        printable_s;
    logic        row_inc_s;
    logic        scroll_s;
    addr_t       cell_addr_s;
    logic        unused_ok_s;

    assign cmd_ready_s = (state_r == S_IDLE) & ~clr;
    assign cmd_fire_s  = bus.cmd_valid & cmd_ready_s;
    assign printable_s = (ch_r != CH_LF) & (ch_r != CH_CR) & (ch_r != CH_BS);
    assign row_inc_s   = (ch_r == CH_LF) | (printable_s & (col_r == COL_MAX));
    assign scroll_s    = row_inc_s & (row_r == ROW_MAX);
    assign cell_addr_s = addr_t'(row_r) * addr_t'(COLS) + addr_t'(col_r);
    // Operand bits the command set never looks at.
    assign unused_ok_s = ^{bus.cmd_data[15:14], bus.cmd_data[7]};

    assign bus.cmd_ready  = cmd_ready_s;
    assign bus.vram_we    = vram_we_r;
    assign bus.vram_waddr = {16'h0000, waddr_r};
    assign bus.vram_wdata = wdata_r;
    assign bus.vram_raddr = {16'h0000, raddr_r};
    assign cur_col        = col_r;
    assign cur_row        = row_r;
    assign busy           = (state_r != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_fire_s) begin
                    case (bus.cmd_op)
                        OP_PUTC:  state_s = S_PUTC;
                        OP_CLEAR: state_s = S_CLEAR;
                        default:  state_s = S_IDLE;
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PUTC:    state_s = S_ADV;
            S_ADV:     state_s = scroll_s ? S_COPY_RD : S_IDLE;
            S_COPY_RD: state_s = S_COPY_WR;
            S_COPY_WR: state_s = (addr_r == COPY_LAST) ? S_BLANK : S_COPY_RD;
            S_BLANK:   state_s = (addr_r == CELL_LAST) ? S_IDLE : S_BLANK;
            S_CLEAR:   state_s = (addr_r == CELL_LAST) ? S_IDLE : S_CLEAR;
            default:   state_s = S_IDLE;
        endcase
    end

    // Output and datapath next values; every VRAM output is registered below.
    always_comb begin
        col_s     = col_r;
        row_s     = row_r;
        color_s   = color_r;
        ch_s      = ch_r;
        addr_s    = addr_r;
        vram_we_s = 1'b0;
        waddr_s   = waddr_r;
        wdata_s   = wdata_r;
        raddr_s   = raddr_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_fire_s) begin
                    case (bus.cmd_op)
                        OP_PUTC:     ch_s    = bus.cmd_data[6:0];
                        OP_CLEAR:    addr_s  = 16'd0;
                        OP_SETCOLOR: color_s = bus.cmd_data[11:0];
                        OP_SETPOS: begin
                            col_s = (bus.cmd_data[6:0] > COL_MAX) ? COL_MAX : bus.cmd_data[6:0];
                            row_s = (bus.cmd_data[13:8] > ROW_MAX) ? ROW_MAX : bus.cmd_data[13:8];
                        end
                        default: ch_s = ch_r;
                    endcase
                end else begin
                    ch_s = ch_r;
                end
            end
            S_PUTC: begin
                if (printable_s) begin
                    vram_we_s = 1'b1;
                    waddr_s   = cell_addr_s;
                    wdata_s   = cell_word(color_r, ch_r);
                end else begin
                    vram_we_s = 1'b0;
                end
            end
            S_ADV: begin
                if ((ch_r == CH_LF) || (ch_r == CH_CR)) begin
                    col_s = 7'd0;
                end else if (ch_r == CH_BS) begin
                    col_s = (col_r != 7'd0) ? (col_r - 7'd1) : col_r;
                end else if (col_r == COL_MAX) begin
                    col_s = 7'd0;
                end else begin
                    col_s = col_r + 7'd1;
                end
                // Row stays at the bottom line while the screen scrolls.
                if (scroll_s) begin
                    addr_s  = 16'd0;
                    raddr_s = SCROLL_SRC;
                end else if (row_inc_s) begin
                    row_s = row_r + 6'd1;
                end else begin
                    row_s = row_r;
                end
            end
            S_COPY_RD: begin
                vram_we_s = 1'b0;
            end
            S_COPY_WR: begin
                // Read data for addr_r+COLS is valid now; next read is issued alongside.
                vram_we_s = 1'b1;
                waddr_s   = addr_r;
                wdata_s   = bus.vram_rdata;
                addr_s    = addr_r + 16'd1;
                if (addr_r != COPY_LAST) begin
                    raddr_s = addr_r + 16'd1 + SCROLL_SRC;
                end else begin
                    raddr_s = raddr_r;
                end
            end
            S_BLANK: begin
                vram_we_s = 1'b1;
                waddr_s   = addr_r;
                wdata_s   = cell_word(color_r, CH_SPACE);
                if (addr_r == CELL_LAST) begin
                    row_s = ROW_MAX;
                end else begin
                    addr_s = addr_r + 16'd1;
                end
            end
            S_CLEAR: begin
                vram_we_s = 1'b1;
                waddr_s   = addr_r;
                wdata_s   = cell_word(color_r, CH_SPACE);
                if (addr_r == CELL_LAST) begin
                    col_s = 7'd0;
                    row_s = 6'd0;
                end else begin
                    addr_s = addr_r + 16'd1;
                end
            end
            default: begin
                vram_we_s = 1'b0;
            end
        endcase
    end

    // Datapath and registered VRAM outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            col_r     <= 7'd0;
            row_r     <= 6'd0;
            color_r   <= DEFAULT_COLOR;
            ch_r      <= 7'd0;
            addr_r    <= 16'd0;
            vram_we_r <= 1'b0;
            waddr_r   <= 16'd0;
            wdata_r   <= 32'd0;
            raddr_r   <= 16'd0;
        end else begin
            col_r     <= col_s;
            row_r     <= row_s;
            color_r   <= color_s;
            ch_r      <= ch_s;
            addr_r    <= addr_s;
            vram_we_r <= vram_we_s;
            waddr_r   <= waddr_s;
            wdata_r   <= wdata_s;
            raddr_r   <= raddr_s;
        end
    end

endmodule

// File: tb/tb_vga_console.sv
// -----------------------------------------------------------------------------
// tb_vga_console
// Scoreboard bench for vga_console: expected VRAM writes are queued when a
// command is issued and popped as the engine writes. A small VRAM model backs
// the read port; a separate reference copy of VRAM supplies scroll data.
// -----------------------------------------------------------------------------
module tb_vga_console;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic [6:0] cur_col;
    logic [5:0] cur_row;
    logic       busy;

    vga_console_if bus();

    vga_console #(
        .COLS(80),
        .ROWS(50),
        .DEFAULT_COLOR(12'hFFF)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus),
        .cur_col(cur_col),
        .cur_row(cur_row),
        .busy(busy)
    );

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;

    logic [63:0] sb_q[$];
    logic [31:0] exp_mem [0:3999];
    logic [31:0] mem [0:4095];
    logic        bd_we = 1'b0;
    logic [11:0] bd_addr = 12'd0;
    logic [31:0] bd_data = 32'd0;

    // VRAM model: backdoor preload, engine writes, one-cycle read latency.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (bus.vram_we === 1'b1 && bus.vram_waddr < 32'd4096) begin
            mem[bus.vram_waddr[11:0]] <= bus.vram_wdata;
        end
        bus.vram_rdata <= mem[bus.vram_raddr[11:0]];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input int addr, input logic [31:0] data);
        sb_q.push_back({32'(addr), data});
        exp_mem[addr] = data;
    endtask

    // Advance to the next falling edge and score any write seen there.
    task automatic cyc();
        logic [63:0] e;
        @(negedge clk);
        if (bus.vram_we === 1'b1) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                check_val("we_expected", {31'd0, bus.vram_we}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("waddr", bus.vram_waddr, e[63:32]);
                check_val("wdata", bus.vram_wdata, e[31:0]);
            end
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] data, input bit keep);
        int  guard;
        logic acc;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 10000) begin
            acc = bus.cmd_ready;
            cyc();
            guard++;
        end
        if (!acc) check_val("accept_tmo", {31'd0, bus.cmd_ready}, 32'd1);
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 20000) begin
            n++;
            cyc();
        end
        if (busy) check_val("idle_tmo", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check_val({tag, "_col"}, 32'(cur_col), 32'(col));
        check_val({tag, "_row"}, 32'(cur_row), 32'(row));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
        check_val({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check_val({tag, "_we"},    {31'd0, bus.vram_we}, 32'd0);
        check_val({tag, "_waddr"}, bus.vram_waddr, 32'd0);
        check_val({tag, "_wdata"}, bus.vram_wdata, 32'd0);
        check_val({tag, "_raddr"}, bus.vram_raddr, 32'd0);
        check_cursor(tag, 0, 0);
    endtask

    int n;
    int w0;

    initial begin
        clr           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 16'd0;

        // Preload VRAM with distinct words while the engine is held in reset.
        bd_we = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            bd_addr    = 12'(i);
            bd_data    = 32'h1000_0000 + 32'(i);
            exp_mem[i] = bd_data;
            cyc();
        end
        bd_we = 1'b0;
        cyc();
        check_reset_outputs("reset");
        clr = 1'b0;
        cyc();
        check_val("ready_after_reset", {31'd0, bus.cmd_ready}, 32'd1);

        // PUTC 'A' at 0,0 with the reset colour; latency check.
        sb_push(0, 32'h0FFF_0041);
        send(2'd0, 16'h0041, 1'b0);
        check_val("putc_ready_e0", {31'd0, bus.cmd_ready}, 32'd0);
        check_val("putc_busy_e0",  {31'd0, busy}, 32'd1);
        cyc();
        check_val("putc_ready_e1", {31'd0, bus.cmd_ready}, 32'd0);
        cyc();
        check_val("putc_ready_e2", {31'd0, bus.cmd_ready}, 32'd1);
        check_cursor("putc_a", 1, 0);

        // Colour change and end-of-line wrap.
        send(2'd2, 16'h00F0, 1'b0);
        send(2'd3, (16'd3 << 8) | 16'd79, 1'b0);
        check_cursor("setpos_79_3", 79, 3);
        sb_push(319, 32'h00F0_0042);
        send(2'd0, 16'h0042, 1'b0);
        wait_idle(n);
        check_cursor("wrap", 0, 4);

        // Clamping, with ignored operand bits set.
        send(2'd3, 16'hC000 | (16'd60 << 8) | 16'd100, 1'b0);
        check_cursor("clamp", 79, 49);

        // Control characters write nothing.
        w0 = wr_cnt;
        send(2'd3, (16'd5 << 8) | 16'd7, 1'b0);
        send(2'd0, 16'h000A, 1'b0);
        wait_idle(n);
        check_cursor("newline", 0, 6);
        send(2'd3, (16'd6 << 8) | 16'd9, 1'b0);
        send(2'd0, 16'h000D, 1'b0);
        wait_idle(n);
        check_cursor("cr", 0, 6);
        send(2'd3, (16'd6 << 8) | 16'd5, 1'b0);
        send(2'd0, 16'h0008, 1'b0);
        wait_idle(n);
        check_cursor("bs", 4, 6);
        check_val("ctrl_no_write", 32'(wr_cnt - w0), 32'd0);

        // Character at the last cell triggers a full scroll.
        send(2'd2, 16'h0FFF, 1'b0);
        send(2'd3, (16'd49 << 8) | 16'd79, 1'b0);
        sb_push(3999, 32'h0FFF_0043);
        for (int a = 0; a < 3920; a++) sb_push(a, exp_mem[a + 80]);
        for (int a = 3920; a < 4000; a++) sb_push(a, 32'h0FFF_0020);
        send(2'd0, 16'h0043, 1'b0);
        cyc();
        cyc();
        wait_idle(n);
        check_val("scroll_busy_cycles", 32'(n), 32'd7920);
        check_cursor("scroll", 0, 49);
        check_val("scroll_sb_empty", 32'(sb_q.size()), 32'd0);
        check_val("raddr_hold", bus.vram_raddr, 32'd3999);

        // CLEAR with cmd_valid held: the next command waits for IDLE.
        for (int a = 0; a < 4000; a++) sb_push(a, 32'h0FFF_0020);
        w0 = wr_cnt;
        send(2'd1, 16'h0000, 1'b1);
        bus.cmd_op   = 2'd3;
        bus.cmd_data = (16'd10 << 8) | 16'd10;
        wait_idle(n);
        check_val("clear_busy_cycles", 32'(n), 32'd4000);
        check_val("clear_writes", 32'(wr_cnt - w0), 32'd4000);
        check_cursor("clear", 0, 0);
        cyc();
        bus.cmd_valid = 1'b0;
        check_cursor("held_setpos", 10, 10);

        // Reset in the middle of a second CLEAR.
        send(2'd2, 16'h0123, 1'b0);
        for (int a = 0; a < 1000; a++) sb_push(a, 32'h0123_0020);
        send(2'd1, 16'h0000, 1'b0);
        repeat (1000) cyc();
        clr = 1'b1;
        cyc();
        check_reset_outputs("midclear");
        check_val("midclear_sb_empty", 32'(sb_q.size()), 32'd0);
        clr = 1'b0;
        cyc();

        // Colour is back to default; backspace at column 0 is a no-op.
        sb_push(0, 32'h0FFF_005A);
        send(2'd0, 16'h005A, 1'b0);
        wait_idle(n);
        check_cursor("putc_z", 1, 0);
        w0 = wr_cnt;
        send(2'd0, 16'h0008, 1'b0);
        wait_idle(n);
        check_cursor("bs1", 0, 0);
        send(2'd0, 16'h0008, 1'b0);
        wait_idle(n);
        check_cursor("bs_col0", 0, 0);
        repeat (3) cyc();
        check_val("bs_no_write", 32'(wr_cnt - w0), 32'd0);
        check_val("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_console.md
Name: vga_console

Overview:
- Command-driven text console engine on the CPU side of the text-mode VRAM.
- Accepts character, clear, colour and cursor commands from the CPU and turns them into VRAM word writes.
- Handles cursor advance, line wrap, newline and hardware scroll; scroll copies VRAM through a read port.
- Produces exactly the cell format the VGA text interface consumes: bits[27:16] = 12-bit RGB colour, bits[6:0] = ASCII code, all other bits 0, address = row*COLS + col.

Parameters:
- COLS, 80, characters per row.
- ROWS, 50, rows on screen.
- DEFAULT_COLOR, 12'hFFF, colour loaded at reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine can accept a command.
- cmd_op  in  2  0=PUTC, 1=CLEAR, 2=SETCOLOR, 3=SETPOS.
- cmd_data  in  16  command operand.
- vram_we  out  1  VRAM write strobe.
- vram_waddr  out  32  VRAM word write address.
- vram_wdata  out  32  VRAM write data.
- vram_raddr  out  32  VRAM word read address (scroll only).
- vram_rdata  in  32  read data, valid one cycle after vram_raddr.
- cur_col  out  7  current cursor column.
- cur_row  out  6  current cursor row.
- busy  out  1  engine not in IDLE.

Behaviour:
- Reset (clr=1 at a clock edge):
  - state=IDLE, cur_col=0, cur_row=0, colour=DEFAULT_COLOR.
  - vram_we=0, vram_waddr=0, vram_wdata=0, vram_raddr=0.
  - busy=0; cmd_ready=0 while clr is high.
  - Reset mid-CLEAR or mid-SCROLL aborts immediately with no further writes; VRAM is left partial.
- Handshake:
  - cmd_ready = (state==IDLE) & !clr.
  - A command is accepted on an edge where cmd_valid & cmd_ready; operands are sampled on that edge.
  - cmd_valid with cmd_ready low is held off with no side effect.
- All write outputs are registered. vram_we is a single-cycle pulse unless stated otherwise.
- PUTC, cmd_data[6:0]=ch:
  - 0x0A: col=0, row+1. No write.
  - 0x0D: col=0. No write.
  - 0x08: if col>0 then col-1. No write; no wrap to the previous row.
  - Any other ch:
    - The cycle after accept: vram_we=1, waddr=row*COLS+col, wdata={4'b0,colour,9'b0,ch}.
    - Then col+1; if col reaches COLS, col=0 and row+1.
  - If the row increment would produce row==ROWS, enter SCROLL and set row=ROWS-1 when the scroll completes.
  - Latency: non-scrolling PUTC returns to IDLE 2 cycles after accept (cmd_ready high again on the 2nd edge).
- SCROLL:
  - COPY phase: for a = 0 .. COLS*(ROWS-1)-1, 2 cycles per word:
    - RD: vram_raddr = a+COLS.
    - WR: vram_we=1, waddr=a, wdata=vram_rdata.
  - BLANK phase: for a = COLS*(ROWS-1) .. COLS*ROWS-1, 1 cycle per word, write the blank word {4'b0,colour,9'b0,7'h20}.
  - Total length = 2*COLS*(ROWS-1) + COLS = 7920 cycles at defaults, then IDLE.
- CLEAR:
  - Writes the blank word to addresses 0 .. COLS*ROWS-1 in ascending order, one per cycle (4000 cycles).
  - Then col=0, row=0, IDLE.
- SETCOLOR: colour=cmd_data[11:0]. Completes in 1 cycle with no write; affects later writes only.
- SETPOS:
  - col = min(cmd_data[6:0], COLS-1), row = min(cmd_data[13:8], ROWS-1); cmd_data[15:14] and [7] ignored.
  - Completes in 1 cycle with no write.
- busy=1 in every state except IDLE.
- Address arithmetic is unsigned; upper address bits are 0.
- vram_raddr holds its last value outside COPY.

Test Plan:
- Reset then PUTC 0x41 → one write, waddr=0, wdata=32'h0FFF_0041; cur_col=1; cmd_ready high 2 cycles after accept.
- SETCOLOR 0x0F0, SETPOS col=79 row=3, PUTC 0x42 → write at addr 319, wdata=32'h00F0_0042; cursor becomes col=0, row=4.
- SETPOS col=100 row=60 → cursor clamps to col=79, row=49. PUTC 0x0A from row 5 col 7 → col=0, row=6, no vram_we.
- SETPOS row=49 col=79, PUTC 0x43 → write at 3999, then scroll:
  - copies read 80→0 … 3999→3919.
  - blanks 3920–3999 with 0x0FFF_0020.
  - busy for exactly 7920 cycles after the char write; final cursor col=0, row=49.
- CLEAR → 4000 consecutive vram_we cycles at addresses 0..3999 with the blank word, cursor 0,0. Assert clr at cycle 1000 of a second CLEAR → vram_we low from the next edge, all outputs at reset values.
- cmd_valid held high through a CLEAR → no second accept until IDLE; 0x08 at col 0 → no change, no write.
